// File: rtl/flash_bus_arbiter.sv
// Arbiter for the shared quad-SPI flash pins: round-robin grant, CS drain guard, bus turnaround.
// Optional grant timeout enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_bus_arbiter #(
  parameter int GUARD_CYC   = 2,
  parameter int TURN_CYC    = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_i,
  input  logic [2:0] cs_n_i,
  input  logic       clr_tmo_i,
  output logic [2:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       cs_force_o,
  output logic       busy_o,
  output logic [2:0] timeout_o
);

  localparam int CNT_LIMIT = (1 << CNT_W) - 1;

  if (GUARD_CYC < 1 || TURN_CYC < 1 || TIMEOUT_CYC < 1 ||
      GUARD_CYC > CNT_LIMIT || TURN_CYC > CNT_LIMIT || TIMEOUT_CYC > CNT_LIMIT) begin : g_bad_param
    $error("flash_bus_arbiter: cycle parameters must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYC - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, TURN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d, rr_q, rr_d, rr_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gnt_d, eligible, tmo_set;
  logic [1:0]       sel_d, win, cand;
  logic             force_d, win_vld, tmo_hit, on_bus_d;

  assign rr_next = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;

  // Round-robin scan; walking backwards lets the nearest candidate to rr_q win.
  always_comb begin
    win_vld = 1'b0;
    win     = rr_q;
    cand    = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      cand = 2'((int'(rr_q) + i) % 3);
      if (eligible[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    tmo_set = 3'b000;
    if (tmo_hit) begin
      state_d          = TURN;
      cnt_d            = '0;
      rr_d             = rr_next;
      tmo_set[owner_q] = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (win_vld) begin
            state_d = GRANT;
            owner_d = win;
          end
        end
        GRANT: begin
          if (!req_i[owner_q]) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
        DRAIN: begin
          if (!cs_n_i[owner_q]) begin
            cnt_d = '0;
          end else if (cnt_q >= GUARD_LAST) begin
            state_d = TURN;
            cnt_d   = '0;
            rr_d    = rr_next;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        TURN: begin
          if (cnt_q >= TURN_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    on_bus_d = (state_d == GRANT) || (state_d == DRAIN);
    gnt_d    = (state_d == GRANT) ? (3'b001 << owner_d) : 3'b000;
    sel_d    = on_bus_d ? owner_d + 2'd1 : 2'd0;
    force_d  = !on_bus_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      rr_q       <= 2'd0;
      cnt_q      <= '0;
      gnt_o      <= 3'b000;
      sel_o      <= 2'd0;
      cs_force_o <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      gnt_o      <= gnt_d;
      sel_o      <= sel_d;
      cs_force_o <= force_d;
      busy_o     <= (state_d != IDLE);
    end
  end

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [2:0]       blocked_q, tmo_q;
  logic             on_bus_q;

  assign on_bus_q  = (state_q == GRANT) || (state_q == DRAIN);
  assign tmo_hit   = on_bus_q && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  // A revoked master stays out of arbitration until it lets go of req_i.
  assign eligible  = req_i & ~blocked_q;
  assign timeout_o = tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      blocked_q <= 3'b000;
      tmo_q     <= 3'b000;
    end else begin
      if (on_bus_q && on_bus_d && tmo_cnt_q != CNT_MAX)
        tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
      else if (!(on_bus_q && on_bus_d))
        tmo_cnt_q <= '0;
      blocked_q <= (blocked_q & req_i) | tmo_set;
      tmo_q     <= (tmo_q & ~{3{clr_tmo_i}}) | tmo_set;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign eligible   = req_i;
  assign timeout_o  = 3'b000;
  assign unused_tmo = clr_tmo_i | (|tmo_set);
`endif

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter (GUARD_CYC=2, TURN_CYC=4, TIMEOUT_CYC=16).
module tb_flash_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_i, cs_n_i;
  logic       clr_tmo_i;
  logic [2:0] gnt_o, timeout_o;
  logic [1:0] sel_o;
  logic       cs_force_o, busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flash_bus_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cs_n_i(cs_n_i), .clr_tmo_i(clr_tmo_i),
    .gnt_o(gnt_o), .sel_o(sel_o), .cs_force_o(cs_force_o), .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_wait(input string tag);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 8'(busy_o), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int order [4] = '{0, 1, 2, 0};

    rst = 1'b1; req_i = 3'b000; cs_n_i = 3'b111; clr_tmo_i = 1'b0;
    tick(); tick();
    chk("rst_gnt",   8'(gnt_o),      8'h00);
    chk("rst_sel",   8'(sel_o),      8'h00);
    chk("rst_force", 8'(cs_force_o), 8'h01);
    chk("rst_busy",  8'(busy_o),     8'h00);
    chk("rst_tmo",   8'(timeout_o),  8'h00);
    rst = 1'b0;
    tick();

    // single request from auth FSM
    req_i = 3'b010;
    tick();
    chk("single_gnt",   8'(gnt_o),      8'h02);
    chk("single_sel",   8'(sel_o),      8'h02);
    chk("single_force", 8'(cs_force_o), 8'h00);
    chk("single_busy",  8'(busy_o),     8'h01);
    tick(); tick();
    chk("single_hold", 8'(gnt_o), 8'h02);
    req_i = 3'b000;
    tick();
    chk("drop_gnt", 8'(gnt_o), 8'h00);
    chk("drop_sel", 8'(sel_o), 8'h02);
    tick();
    chk("drain1_sel", 8'(sel_o), 8'h02);
    tick();
    chk("turn_sel",   8'(sel_o),      8'h00);
    chk("turn_force", 8'(cs_force_o), 8'h01);
    chk("turn_busy",  8'(busy_o),     8'h01);
    tick(); tick(); tick();
    chk("turn3_busy", 8'(busy_o), 8'h01);
    tick();
    chk("idle_busy", 8'(busy_o), 8'h00);

    // asynchronous reset in the middle of a grant
    req_i = 3'b001;
    tick();
    chk("prerst_gnt", 8'(gnt_o), 8'h01);
    rst = 1'b1;
    #1;
    chk("rstmid_gnt",   8'(gnt_o),      8'h00);
    chk("rstmid_sel",   8'(sel_o),      8'h00);
    chk("rstmid_force", 8'(cs_force_o), 8'h01);
    chk("rstmid_busy",  8'(busy_o),     8'h00);
    req_i = 3'b000;
    tick();
    rst = 1'b0;
    tick();

    // all three request together; each lets go after 5 granted cycles
    req_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (gnt_o == 3'b000 && gap < 40);
      chk($sformatf("rr%0d_gap", k), 8'(gap), (k == 0) ? 8'd1 : 8'd7);
      chk($sformatf("rr%0d_gnt", k), 8'(gnt_o), 8'(3'b001 << order[k]));
      chk($sformatf("rr%0d_sel", k), 8'(sel_o), 8'(order[k] + 1));
      repeat (4) tick();
      chk($sformatf("rr%0d_hold", k), 8'(gnt_o), 8'(3'b001 << order[k]));
      req_i[order[k]] = 1'b0;
      tick();
      chk($sformatf("rr%0d_drop", k), 8'(gnt_o), 8'h00);
      if (k < 3) req_i[order[k]] = 1'b1;
    end
    req_i = 3'b000;
    idle_wait("rr_idle");

    // owner keeps cs_n low after dropping its request
    req_i = 3'b010;
    tick();
    chk("dh_gnt", 8'(gnt_o), 8'h02);
    req_i  = 3'b000;
    cs_n_i = 3'b101;
    tick();
    chk("dh_drop_gnt", 8'(gnt_o), 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("dh_low%0d_sel", i), 8'(sel_o), 8'h02);
      chk($sformatf("dh_low%0d_force", i), 8'(cs_force_o), 8'h00);
    end
    cs_n_i = 3'b111;
    tick();
    chk("dh_h1_sel", 8'(sel_o), 8'h02);
    cs_n_i = 3'b101;
    tick();
    chk("dh_glitch_sel", 8'(sel_o), 8'h02);
    cs_n_i = 3'b111;
    tick();
    chk("dh_h2_sel", 8'(sel_o), 8'h02);
    tick();
    chk("dh_turn_sel",   8'(sel_o),      8'h00);
    chk("dh_turn_force", 8'(cs_force_o), 8'h01);
    idle_wait("dh_idle");

    // MCU request arriving during TURN waits for IDLE arbitration
    req_i = 3'b001;
    tick();
    chk("lr_gnt0", 8'(gnt_o), 8'h01);
    req_i = 3'b000;
    tick(); tick(); tick();
    chk("lr_turn_sel",  8'(sel_o),  8'h00);
    chk("lr_turn_busy", 8'(busy_o), 8'h01);
    req_i = 3'b100;
    tick();
    chk("lr_t1_gnt", 8'(gnt_o), 8'h00);
    tick(); tick();
    chk("lr_t3_gnt", 8'(gnt_o), 8'h00);
    tick();
    chk("lr_idle_busy", 8'(busy_o), 8'h00);
    chk("lr_idle_gnt",  8'(gnt_o),  8'h00);
    tick();
    chk("lr_gnt2", 8'(gnt_o), 8'h04);
    chk("lr_sel2", 8'(sel_o), 8'h03);

`ifdef FLASH_ARB_TIMEOUT_EN
    req_i = 3'b000;
    idle_wait("to_pre_idle");
    req_i = 3'b010;
    tick();
    chk("to_gnt", 8'(gnt_o), 8'h02);
    repeat (15) tick();
    chk("to_gnt16", 8'(gnt_o), 8'h02);
    chk("to_noflag", 8'(timeout_o), 8'h00);
    tick();
    chk("to_revoked", 8'(gnt_o),      8'h00);
    chk("to_flag",    8'(timeout_o),  8'h02);
    chk("to_sel",     8'(sel_o),      8'h00);
    chk("to_force",   8'(cs_force_o), 8'h01);
    repeat (8) tick();
    chk("to_block_gnt",  8'(gnt_o),     8'h00);
    chk("to_block_busy", 8'(busy_o),    8'h00);
    chk("to_sticky",     8'(timeout_o), 8'h02);
    clr_tmo_i = 1'b1;
    tick();
    clr_tmo_i = 1'b0;
    chk("to_clr", 8'(timeout_o), 8'h00);
    req_i = 3'b000;
    tick();
    req_i = 3'b010;
    tick();
    chk("to_regnt", 8'(gnt_o), 8'h02);
    req_i = 3'b000;
    idle_wait("to_idle");
`else
    repeat (20) tick();
    chk("nt_long_gnt", 8'(gnt_o),     8'h04);
    chk("nt_tmo",      8'(timeout_o), 8'h00);
    clr_tmo_i = 1'b1;
    tick();
    clr_tmo_i = 1'b0;
    chk("nt_clr_gnt", 8'(gnt_o), 8'h04);
    req_i = 3'b000;
    idle_wait("nt_idle");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
